multicycle_ctrl: RTL and testbench

Multicycle sequencer for the RFplusALU datapath of the MulticycleRISC core. Fetches each 16-bit instruction over a req/ack memory handshake, decodes its opcode, and walks FETCH→DECODE→EXECUTE→(MEM)→(WB), driving every RFplusALU control input (WBRF, RBresource, WBresource, OprandB, LI, Buff_IDEXE, ALUop, Flag, PSW_C). It also issues PC and IR strobes.

---
 rtl/multicycle_pkg.sv | 46 ++++
 rtl/ins_decoder.sv | 70 +++++++
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared opcode values, FSM state encoding and decoded control word for multicycle_ctrl.
package multicycle_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADC  = 4'h3;
  localparam logic [3:0] OP_SBB  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_BNZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  // no_exec marks instructions that retire straight out of DECODE (NOP and illegal).
  typedef struct packed {
    logic alu_op;
    logic psw_c;
    logic oprand_b;
    logic li;
    logic flag;
    logic rb_res;
    logic wb_res;
    logic is_mem;
    logic is_store;
    logic is_branch;
    logic writes_rf;
    logic illegal;
    logic is_halt;
    logic no_exec;
  } ctrl_t;

endpackage

// File: rtl/ins_decoder.sv
// Combinational opcode to control-word decoder; undefined opcodes decode as NOP with illegal set.
module ins_decoder
  import multicycle_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_NOP:  ctrl_o.no_exec = 1'b1;
      OP_ADD: begin
        ctrl_o.flag      = 1'b1;
        ctrl_o.writes_rf = 1'b1;
      end
      OP_SUB: begin
        ctrl_o.alu_op    = 1'b1;
        ctrl_o.flag      = 1'b1;
        ctrl_o.writes_rf = 1'b1;
      end
      OP_ADC: begin
        ctrl_o.psw_c     = 1'b1;
        ctrl_o.flag      = 1'b1;
        ctrl_o.writes_rf = 1'b1;
      end
      OP_SBB: begin
        ctrl_o.alu_op    = 1'b1;
        ctrl_o.psw_c     = 1'b1;
        ctrl_o.flag      = 1'b1;
        ctrl_o.writes_rf = 1'b1;
      end
      OP_CMP: begin
        ctrl_o.alu_op = 1'b1;
        ctrl_o.flag   = 1'b1;
      end
      OP_ADDI: begin
        ctrl_o.oprand_b  = 1'b1;
        ctrl_o.flag      = 1'b1;
        ctrl_o.writes_rf = 1'b1;
      end
      OP_LI: begin
        ctrl_o.li        = 1'b1;
        ctrl_o.writes_rf = 1'b1;
      end
      OP_LD: begin
        ctrl_o.oprand_b  = 1'b1;
        ctrl_o.is_mem    = 1'b1;
        ctrl_o.wb_res    = 1'b1;
        ctrl_o.writes_rf = 1'b1;
      end
      OP_ST: begin
        ctrl_o.oprand_b = 1'b1;
        ctrl_o.is_mem   = 1'b1;
        ctrl_o.is_store = 1'b1;
        ctrl_o.rb_res   = 1'b1;
      end
      OP_BZ, OP_BNZ, OP_JMP: begin
        ctrl_o.oprand_b  = 1'b1;
        ctrl_o.is_branch = 1'b1;
      end
      OP_HLT:  ctrl_o.is_halt = 1'b1;
      default: begin
        ctrl_o.illegal = 1'b1;
        ctrl_o.no_exec = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving the RFplusALU controls.
// Define CTRL_MEM_TIMEOUT_EN to abandon a memory wait after TIMEOUT cycles without mem_ack.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [15:0] Ins,
  input  logic        Z,
  input  logic        C,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        IR_load,
  output logic        PC_inc,
  output logic        PC_load,
  output logic        WBRF,
  output logic        RBresource,
  output logic        WBresource,
  output logic        OprandB,
  output logic        LI,
  output logic        Buff_IDEXE,
  output logic        ALUop,
  output logic        Flag,
  output logic        PSW_C,
  output logic        halted,
  output logic        illegal_op,
  output logic        bus_err
);

  state_e     state_q, state_d;
  ctrl_t      ctl;
  logic [3:0] opcode;
  logic       take_branch;
  logic       tmo;
  logic       unused_ok;

  assign opcode    = Ins[15:12];
  assign unused_ok = ^{Ins[11:0], C, TIMEOUT[0]};

  ins_decoder u_dec (
    .opcode_i (opcode),
    .ctrl_o   (ctl)
  );

  assign take_branch = (opcode == OP_JMP) || (opcode == OP_BZ && Z) || (opcode == OP_BNZ && !Z);

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;

  // cnt_q counts wait cycles already spent in the current FETCH/MEM visit.
  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
  assign tmo     = waiting && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));
  assign cnt_d   = (waiting && state_d == state_q && !tmo) ? cnt_q + 1'b1 : '0;
  assign bus_err = tmo && !Reset;

  always_ff @(posedge clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    IR_load    = 1'b0;
    PC_inc     = 1'b0;
    PC_load    = 1'b0;
    WBRF       = 1'b0;
    RBresource = 1'b0;
    WBresource = 1'b0;
    OprandB    = 1'b0;
    LI         = 1'b0;
    Buff_IDEXE = 1'b0;
    ALUop      = 1'b0;
    Flag       = 1'b0;
    PSW_C      = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    if (Reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (tmo) begin
            state_d = S_FETCH;
          end else if (mem_ack) begin
            IR_load = 1'b1;
            PC_inc  = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          Buff_IDEXE = 1'b1;
          RBresource = ctl.rb_res;
          illegal_op = ctl.illegal;
          if (ctl.no_exec)      state_d = S_FETCH;
          else if (ctl.is_halt) state_d = S_HALT;
          else                  state_d = S_EXECUTE;
        end
        S_EXECUTE: begin
          ALUop   = ctl.alu_op;
          PSW_C   = ctl.psw_c;
          OprandB = ctl.oprand_b;
          LI      = ctl.li;
          Flag    = ctl.flag;
          if (ctl.is_branch) begin
            PC_load = take_branch;
            state_d = S_FETCH;
          end else if (ctl.is_mem) begin
            state_d = S_MEM;
          end else if (ctl.writes_rf) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = ctl.is_store;
          if (tmo)          state_d = S_FETCH;
          else if (mem_ack) state_d = ctl.is_store ? S_FETCH : S_WB;
        end
        S_WB: begin
          WBRF       = 1'b1;
          WBresource = ctl.wb_res;
          state_d    = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl; expected per-cycle outputs come from a phase-level model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic mem_req, mem_we, mem_sel, IR_load, PC_inc, PC_load, WBRF, RBresource, WBresource;
    logic OprandB, LI, Buff_IDEXE, ALUop, Flag, PSW_C, halted, illegal_op, bus_err;
  } ov_t;

  typedef struct {
    logic        rst;
    logic [15:0] ins;
    logic        z;
    logic        ack;
    ov_t         exp;
  } cyc_t;

  logic        clk;
  logic        Reset;
  logic [15:0] Ins;
  logic        Z, C, mem_ack;
  logic mem_req, mem_we, mem_sel, IR_load, PC_inc, PC_load, WBRF, RBresource, WBresource;
  logic OprandB, LI, Buff_IDEXE, ALUop, Flag, PSW_C, halted, illegal_op, bus_err;
  ov_t         act;

  int          n_vec;
  int          n_bad;
  ov_t         exp_q[$];
  cyc_t        pend[$];
  logic [15:0] cur_ins;

  multicycle_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .Reset(Reset), .Ins(Ins), .Z(Z), .C(C), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .IR_load(IR_load),
    .PC_inc(PC_inc), .PC_load(PC_load), .WBRF(WBRF), .RBresource(RBresource),
    .WBresource(WBresource), .OprandB(OprandB), .LI(LI), .Buff_IDEXE(Buff_IDEXE),
    .ALUop(ALUop), .Flag(Flag), .PSW_C(PSW_C), .halted(halted),
    .illegal_op(illegal_op), .bus_err(bus_err)
  );

  assign act = {mem_req, mem_we, mem_sel, IR_load, PC_inc, PC_load, WBRF, RBresource, WBresource,
                OprandB, LI, Buff_IDEXE, ALUop, Flag, PSW_C, halted, illegal_op, bus_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic cyc_t mk(input logic [15:0] ins, input logic z, input logic ack, input ov_t o);
    cyc_t c;
    c.rst = 1'b0;
    c.ins = ins;
    c.z   = z;
    c.ack = ack;
    c.exp = o;
    return c;
  endfunction

  // One cycle: inputs change just after the rising edge, expectation queued for the monitor.
  task automatic drive(input cyc_t c);
    @(posedge clk);
    #1;
    Reset   = c.rst;
    Ins     = c.ins;
    Z       = c.z;
    C       = rbit();
    mem_ack = c.ack;
    cur_ins = c.ins;
    exp_q.push_back(c.exp);
  endtask

  task automatic do_reset(input int n, input bit rnd_ack);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c     = mk($urandom, rbit(), rnd_ack ? rbit() : 1'b1, '0);
      c.rst = 1'b1;
      drive(c);
    end
  endtask

  // Expected cycle-by-cycle trace of one instruction, built from the phase rules.
  task automatic gen_instr(input logic [15:0] ins, input int fw, input int mw, input logic zv);
    logic [3:0] op;
    ov_t        o;
    op = ins[15:12];
    pend.delete();
    for (int i = 0; i < fw; i++) begin
      o = '0; o.mem_req = 1'b1;
      pend.push_back(mk(cur_ins, rbit(), 1'b0, o));
    end
    o = '0; o.mem_req = 1'b1; o.IR_load = 1'b1; o.PC_inc = 1'b1;
    pend.push_back(mk(cur_ins, rbit(), 1'b1, o));
    o = '0; o.Buff_IDEXE = 1'b1; o.RBresource = (op == 4'h9); o.illegal_op = (op inside {4'hD, 4'hE});
    pend.push_back(mk(ins, rbit(), rbit(), o));
    if (op == 4'hF) begin
      for (int i = 0; i < 8; i++) begin
        o = '0; o.halted = 1'b1;
        pend.push_back(mk(ins, rbit(), i[0], o));
      end
    end else if (!(op inside {4'h0, 4'hD, 4'hE})) begin
      o = '0;
      o.ALUop   = (op inside {4'h2, 4'h4, 4'h5});
      o.PSW_C   = (op inside {4'h3, 4'h4});
      o.OprandB = (op inside {4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC});
      o.LI      = (op == 4'h7);
      o.Flag    = (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6});
      o.PC_load = (op == 4'hC) || (op == 4'hA && zv) || (op == 4'hB && !zv);
      pend.push_back(mk(ins, zv, rbit(), o));
      if (op inside {4'h8, 4'h9}) begin
        o = '0; o.mem_req = 1'b1; o.mem_sel = 1'b1; o.mem_we = (op == 4'h9);
        for (int i = 0; i < mw; i++) pend.push_back(mk(ins, rbit(), 1'b0, o));
        pend.push_back(mk(ins, rbit(), 1'b1, o));
      end
      if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8}) begin
        o = '0; o.WBRF = 1'b1; o.WBresource = (op == 4'h8);
        pend.push_back(mk(ins, rbit(), rbit(), o));
      end
    end
  endtask

  task automatic run(input int abort_at);
    for (int i = 0; i < pend.size(); i++) begin
      if (i == abort_at) break;
      drive(pend[i]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ov_t e;
        e = exp_q.pop_front();
        n_vec++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL vec%0d outputs: got %b expected %b (t=%0t)", n_vec, act, e, $time);
        end
      end
    end
  end

  initial begin
    ov_t o;
    int  abort_at;
    n_vec   = 0;
    n_bad   = 0;
    cur_ins = '0;
    Reset   = 1'b1;
    Ins     = '0;
    Z       = 1'b0;
    C       = 1'b0;
    mem_ack = 1'b0;

    do_reset(3, 1'b0);
    gen_instr(16'h1234, 0, 0, 1'b0); run(-1);
    gen_instr(16'h8abc, 0, 2, 1'b0); run(-1);
    gen_instr(16'hA001, 0, 0, 1'b1); run(-1);
    gen_instr(16'hA001, 0, 0, 1'b0); run(-1);
    gen_instr(16'h9055, 1, 1, 1'b0); run(-1);

    // Long fetch stall: with the timeout build the 15th cycle reports bus_err and restarts.
    for (int i = 0; i < 20; i++) begin
      o = '0; o.mem_req = 1'b1;
`ifdef CTRL_MEM_TIMEOUT_EN
      if (i == 14) o.bus_err = 1'b1;
`endif
      drive(mk(cur_ins, rbit(), 1'b0, o));
    end
    gen_instr(16'h5111, 0, 0, 1'b0); run(-1);

    gen_instr(16'hD000, 0, 0, 1'b0); run(-1);
    gen_instr(16'hF000, 0, 0, 1'b0); run(-1);
    do_reset(2, 1'b1);

    for (int n = 0; n < 300; n++) begin
      gen_instr({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(0, 2),
                $urandom_range(0, 2), rbit());
      abort_at = -1;
      if ($urandom_range(0, 19) == 0) abort_at = $urandom_range(0, pend.size() - 1);
      run(abort_at);
      if (abort_at >= 0) do_reset($urandom_range(1, 2), 1'b1);
    end

    gen_instr(16'hF0F0, 0, 0, 1'b0); run(-1);
    do_reset(1, 1'b1);
    gen_instr(16'h7001, 0, 0, 1'b0); run(-1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked vectors, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
